// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state encoding
// and the default frame geometry.
package fifo_uart_pkg;

   // Transmitter sequencing states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } state_t;

   // Default data bits per frame; must track the FIFO word width
   localparam int DEF_WIDTH        = 6;
   // Default clock cycles per serial bit
   localparam int DEF_CLKS_PER_BIT = 16;

endpackage : fifo_uart_pkg

// File: rtl/fifo_uart_tx_baud_tick.sv
// Baud-rate counter: counts 0..CLKS_PER_BIT-1 and wraps, with a synchronous
// clear that restarts a bit period and a terminal-count flag marking the
// final cycle of each bit.
module fifo_uart_tx_baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   output logic tick_o
);

   localparam int             CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear restarts the period, terminal count wraps to zero
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear_i || (cnt_q == CNT_MAX)) begin
         cnt_d = '0;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == CNT_MAX);

endmodule : fifo_uart_tx_baud_tick

// File: rtl/fifo_uart_tx.sv
// FIFO-drain UART transmitter. Pops one word from the FIFO read port, then
// sends start bit, WIDTH data bits LSB first, and one stop bit on tx.
// tx is registered from the next state so each state's line level appears
// on the cycle the state is entered.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_rd_en,
   output logic             tx,
   output logic             busy,
   output logic             frame_done
);

   localparam int             BCW      = $clog2(WIDTH + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;
   logic [BCW-1:0]   bit_cnt_q;
   logic [BCW-1:0]   bit_cnt_d;
   logic             tx_q;
   logic             tx_d;
   logic             baud_clr;
   logic             bit_end;

   fifo_uart_tx_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .reset   (reset),
      .clear_i (baud_clr),
      .tick_o  (bit_end)
   );

   // Next-state, datapath updates and strobes for the frame sequencer
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      baud_clr   = 1'b0;
      fifo_rd_en = 1'b0;
      frame_done = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A pop is never issued while reset is held, even if the
            // registered state still reads IDLE.
            fifo_rd_en = enable & ~fifo_empty & ~reset;
            if (fifo_rd_en) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            // FIFO registered the word on the pop edge; capture it and
            // align the baud counter to the start of the start bit.
            shift_d   = fifo_data;
            bit_cnt_d = '0;
            baud_clr  = 1'b1;
            state_d   = ST_START;
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + BCW'(1);
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               frame_done = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Line level is a function of the state being entered
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   // State, shift register, bit counter and line register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
      end
   end

   assign tx   = tx_q;
   assign busy = (state_q != ST_IDLE);

endmodule : fifo_uart_tx

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drain-side consumer for the 6-bit synchronous FIFO. Pops one word at a time through the FIFO read port (`read_en`/`empty`/`data_out`) and serializes each word onto a single-wire asynchronous line: start bit, `WIDTH` data bits LSB first, then one stop bit. Sits between the FIFO's read side and the chip output pin, so the FIFO serves as the transmit buffer for whatever writer fills it.

## Interface
- `WIDTH`, 6, data bits per frame; must equal the FIFO `WIDTH`.
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; legal range ≥ 2.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `enable`  in  1  permits starting a new frame; a frame in progress always completes.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  WIDTH  FIFO `data_out`; valid in the cycle after a pop.
- `fifo_rd_en`  out  1  FIFO `read_en`; one-cycle pop strobe.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high from pop through the end of the stop bit.
- `frame_done`  out  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- FSM states: `IDLE`, `FETCH`, `START`, `DATA`, `STOP`.
- `IDLE`:
  - `fifo_rd_en = enable & ~fifo_empty`. This is combinational from the registered state and the inputs.
  - If it is asserted, go to `FETCH`. Otherwise stay in `IDLE`.
- `FETCH`:
  - Lasts one cycle. `fifo_data` is now valid (the FIFO registered it on the pop edge).
  - Load `fifo_data` into the shift register, clear the bit counter and the baud counter, and go to `START`.
- `START`: `tx = 0` for `CLKS_PER_BIT` cycles, then go to `DATA`.
- `DATA`:
  - `tx = shift[0]`. Each bit lasts `CLKS_PER_BIT` cycles.
  - At each bit end, shift right by one and increment the bit counter.
  - After `WIDTH` bits, go to `STOP`.
- `STOP`:
  - `tx = 1` for `CLKS_PER_BIT` cycles.
  - `frame_done = 1` in the final cycle, then go to `IDLE`.
- `tx` is registered: a state's output value appears on the cycle the state is entered.
- `tx` is 1 in `IDLE` and `FETCH`. `busy = (state != IDLE)`.
- Baud counter:
  - Width is `$clog2(CLKS_PER_BIT)`.
  - Counts 0 to `CLKS_PER_BIT-1`, then wraps to 0.
  - A bit ends on the cycle with count == `CLKS_PER_BIT-1`.
- Bit counter: width `$clog2(WIDTH+1)`; no arithmetic wider than the counters.
- `fifo_rd_en` is asserted only in `IDLE`. Exactly one pop per frame, never two pops without an intervening frame.
- `enable` deasserted mid-frame: no effect until return to `IDLE`; the block then holds in `IDLE`.
- `fifo_empty` asserted in `IDLE`: no pop; `tx` stays 1 indefinitely.

## Timing
- Reset values: state `IDLE`, `tx=1`, `busy=0`, `frame_done=0`, `fifo_rd_en=0`, counters 0, shift register 0.
- Reset mid-frame: `tx` returns to 1 on the next edge. The partial frame is abandoned; the popped word is lost.
- `fifo_rd_en` is forced 0 while `reset` is high.
- Latency, with the pop at cycle 0:
  - `FETCH` at cycle 1.
  - Start bit begins at cycle 2.
  - First data bit at cycle 2+`CLKS_PER_BIT`.
  - Stop bit at cycle 2+(WIDTH+1)·`CLKS_PER_BIT`.
  - `frame_done` at cycle 1+(WIDTH+2)·`CLKS_PER_BIT`.
- Back-to-back frames: the earliest next pop is the cycle after `frame_done`. The extra 2 high cycles (`IDLE`+`FETCH`) extend the stop bit, which is legal for the line protocol.
- Frame period with a continuously non-empty FIFO: (WIDTH+2)·`CLKS_PER_BIT` + 2 cycles.

## Structure
- Shared package `fifo_uart_pkg`:
  - FSM state enum.
  - Default `WIDTH` (6) and `CLKS_PER_BIT` (16) constants.
- Optional sub-module `baud_tick`: baud counter with synchronous clear and a terminal-count output.
- Everything else lives in one module.
- Top-level integration instantiates the FIFO and this block, wired `read_en`↔`fifo_rd_en`, `empty`↔`fifo_empty`, `data_out`↔`fifo_data`.

## Test plan
All scenarios use `CLKS_PER_BIT=4` unless stated.
- Reset, then `enable=1`, FIFO empty for 50 cycles → `tx=1`, `busy=0`, `fifo_rd_en` never asserted.
- Write 6'b101101, `enable=1`:
  - Exactly one `fifo_rd_en` pulse.
  - `tx` bit sequence 0,1,0,1,1,0,1,1, each held 4 cycles.
  - Start bit begins 2 cycles after the pop.
  - `frame_done` 33 cycles after the pop.
- Write 3 words (6'h3F, 6'h00, 6'h15):
  - Three frames with 2 idle-high cycles between them.
  - Exactly 3 pops, and the FIFO ends empty.
- Drop `enable` during the `DATA` state of frame 1 with 2 words queued:
  - Frame 1 completes intact; no further pop while `enable=0`.
  - Re-raising `enable` sends word 2.
- Assert `reset` in the 3rd data bit → `tx=1`, `busy=0` on the next edge; no `frame_done`.
- `CLKS_PER_BIT=2`, `WIDTH=6`, word 6'h2A → frame of 16 cycles; bit values 0,0,1,0,1,0,1,1.
